sram_word_array: RTL and testbench
==================================

# sram_word_array

Parametrised, clocked memory array of DEPTH words × WIDTH bits, the successor to the single 8-bit word cell. It adds address decoding, a registered read port with a one-cycle valid strobe, and a sequential clear engine that zeroes the whole array one word per cycle while signalling busy. It sits between the test/host interface and the storage cells as the first multi-word memory macro in the design.

## Interface
- WIDTH, 8, bits per word (≥1)
- DEPTH, 16, number of words (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- sel  input  1  request strobe; sampled each edge
- rw  input  1  1 = write, 0 = read (same polarity as word cell)
- addr  input  ADDR_W  word address
- data_in  input  WIDTH  write data; ignored on reads
- clear  input  1  start array clear
- data_out  output  WIDTH  registered read data; holds last read value
- rd_valid  output  1  one-cycle pulse: data_out updated this cycle
- busy  output  1  clear in progress; requests ignored

## Operation
- FSM states: IDLE, CLEAR.
- IDLE, clear=1: enter CLEAR, clear counter ← 0; clear wins over sel in the same cycle (request dropped, no write, no rd_valid).
- IDLE, sel=1, rw=1, addr<DEPTH: mem[addr] ← data_in. No change to data_out/rd_valid.
- IDLE, sel=1, rw=0, addr<DEPTH: data_out ← mem[addr], rd_valid=1 next cycle.
- addr ≥ DEPTH: write discarded; read returns data_out=0 with rd_valid=1.
- sel=0: no storage change; data_out holds; rd_valid=0.
- CLEAR: each cycle mem[cnt] ← 0, cnt ← cnt+1; after writing cnt=DEPTH-1 return to IDLE. sel, rw and clear all ignored in CLEAR (no queueing). data_out is not altered by the clear.
- Counter width ADDR_W; never wraps beyond DEPTH-1.
- Reset (any time, including mid-CLEAR): state IDLE, all mem words 0, data_out=0, rd_valid=0, busy=0, counter 0. Aborted clear is not resumed.

## Timing
- Read latency 1: request at edge N → data_out valid and rd_valid=1 after edge N+1, for exactly one cycle unless another read follows.
- Back-to-back reads every cycle supported; rd_valid stays high continuously.
- Write at edge N is visible to a read sampled at edge N+1.
- busy is a registered state decode: high from the edge sampling clear through DEPTH cycles; first request accepted at the edge where busy has just returned low (i.e. DEPTH+1 edges after clear is sampled).
- No combinational path from any input to any output.

## Structure
- Package sram_pkg: state enum (ST_IDLE, ST_CLEAR), constants RW_READ=1'b0, RW_WRITE=1'b1.
- Sub-module sram_word: WIDTH-bit register with async active-low reset to 0, synchronous we and d; instantiated DEPTH times via generate. Top holds decoder, read mux, output register, FSM and counter.

## Test plan
- Reset: rst_n=0 for 2 cycles, then read all 16 addresses → data_out=8'h00 each, rd_valid one pulse per read.
- Write/read: write 8'h55 to addr 3, 8'hA0 to addr 15; read 3 then 15 back-to-back → 8'h55 then 8'hA0 on consecutive cycles, rd_valid high both.
- Hold: after read returning 8'hA0, sel=0 for 5 cycles → data_out stays 8'hA0, rd_valid=0.
- Clear: fill addrs 0–15 with 8'hFF, pulse clear with sel=1,rw=1,addr=5,data_in=8'h12 same cycle → busy high 16 cycles, addr 5 not written; all reads afterwards return 8'h00; write attempt during busy has no effect.
- Reset mid-clear: fill with 8'hFF, clear, assert rst_n=0 after 4 busy cycles → busy=0 immediately, all words read 8'h00, FSM in IDLE.
- Out-of-range (DEPTH=10): write 8'h77 to addr 12, read addr 12 → data_out=8'h00, rd_valid=1; addr 0–9 unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the word-array memory macro.
//   state_e  : clear-engine FSM states
//   RW_READ  : rw encoding for a read request
//   RW_WRITE : rw encoding for a write request (same polarity as the word cell)
package sram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage : sram_pkg

// File: rtl/sram_word.sv
// Single storage word: WIDTH-bit register with a synchronous write enable.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the word to 0
//   we    : write enable, d is captured on the next rising edge
//   d     : write data
//   q     : stored word
module sram_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: every storage word has a real async reset; the array must read as
  // all-zero immediately after reset, including when a clear was aborted.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers sample values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule : sram_word

// File: rtl/sram_word_array.sv
// DEPTH x WIDTH memory array with a registered read port and a clear engine.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (array, FSM, counter, outputs)
//   sel      : request strobe, sampled on each edge while idle
//   rw       : 1 = write, 0 = read
//   addr     : word address; addresses >= DEPTH drop writes and read as 0
//   data_in  : write data
//   clear    : start a clear of the whole array (wins over sel)
//   data_out : registered read data, holds the last read value
//   rd_valid : one-cycle strobe, data_out was updated by the last edge
//   busy     : clear in progress, all requests ignored
module sram_word_array
  import sram_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clear,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] cnt;
  logic              req_ok;
  logic              rd_en;
  logic              wr_en;
  logic [DEPTH-1:0]  word_we;
  logic [WIDTH-1:0]  word_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_word;

  // Storage cells.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    sram_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (word_we[i]),
      .d     (word_d),
      .q     (mem_q[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (clear) state_next = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_IDX) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / control decode. busy is a pure decode of the state register,
  // so it has no combinational path from any input.
  always_comb begin
    busy    = (state == ST_CLEAR);
    req_ok  = (state == ST_IDLE) && sel && !clear;
    rd_en   = req_ok && (rw == RW_READ);
    wr_en   = req_ok && (rw == RW_WRITE);
    word_d  = busy ? '0 : data_in;
    word_we = '0;
    // Only in-range indices exist in the decoder, so an address >= DEPTH
    // matches no word and the write is silently dropped.
    for (int i = 0; i < DEPTH; i++) begin
      if (busy) begin
        word_we[i] = (cnt == ADDR_W'(i));
      end else begin
        word_we[i] = wr_en && (addr == ADDR_W'(i));
      end
    end
  end

  // Read mux; an out-of-range address matches nothing and reads as 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) rd_word = mem_q[i];
    end
  end

  // Read output register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      cnt      <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= rd_word;
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (cnt == LAST_IDX) begin
        cnt <= '0;  // last word written, never step past DEPTH-1
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule : sram_word_array

// File: tb/tb_sram_word_array.sv
// Bench for sram_word_array: two instances (DEPTH 16 and DEPTH 10) share one
// stimulus stream. A reference model computes each read result when the
// request is issued and queues it; a monitor on the falling edge pops and
// compares whenever a DUT raises rd_valid, and checks busy and data_out hold.
`timescale 1ns/1ps
module tb_sram_word_array;

  localparam int N_DUT = 2;
  localparam int DEPTHS [N_DUT] = '{16, 10};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       clear = 1'b0;

  logic [7:0] dout [N_DUT];
  logic       rdv  [N_DUT];
  logic       bsy  [N_DUT];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] mem_m      [N_DUT][16];
  int         clear_left [N_DUT];
  logic       exp_valid  [N_DUT];
  logic       exp_busy   [N_DUT];
  logic [7:0] last_read  [N_DUT];
  logic [7:0] sb         [N_DUT][$];

  always #5 clk = ~clk;

  sram_word_array #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr),
    .data_in(data_in), .clear(clear),
    .data_out(dout[0]), .rd_valid(rdv[0]), .busy(bsy[0])
  );

  sram_word_array #(.WIDTH(8), .DEPTH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr),
    .data_in(data_in), .clear(clear),
    .data_out(dout[1]), .rd_valid(rdv[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_DUT; k++) begin
      for (int a = 0; a < 16; a++) mem_m[k][a] = 8'h00;
      clear_left[k] = 0;
      exp_valid[k]  = 1'b0;
      exp_busy[k]   = 1'b0;
      last_read[k]  = 8'h00;
      sb[k].delete();
    end
  endtask

  // Behaviour of one rising edge, written from the operational rules.
  task automatic model_edge(input logic s, input logic r, input logic [3:0] a,
                            input logic [7:0] d, input logic c);
    for (int k = 0; k < N_DUT; k++) begin
      exp_valid[k] = 1'b0;
      if (rst_n) begin
        if (clear_left[k] > 0) begin
          mem_m[k][DEPTHS[k] - clear_left[k]] = 8'h00;
          clear_left[k]--;
        end else if (c) begin
          clear_left[k] = DEPTHS[k];
        end else if (s) begin
          if (r) begin
            if (int'(a) < DEPTHS[k]) mem_m[k][a] = d;
          end else begin
            exp_valid[k] = 1'b1;
            sb[k].push_back((int'(a) < DEPTHS[k]) ? mem_m[k][a] : 8'h00);
          end
        end
      end
      exp_busy[k] = (clear_left[k] > 0);
    end
  endtask

  // Apply inputs, let one rising edge happen, then move 1 ns past it.
  task automatic step(input logic s, input logic r, input logic [3:0] a,
                      input logic [7:0] d, input logic c);
    sel = s; rw = r; addr = a; data_in = d; clear = c;
    @(posedge clk);
    model_edge(s, r, a, d, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < N_DUT; k++) check($sformatf("reset_busy[%0d]", k), bsy[k], 0);
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 4'(a), v, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("busy[%0d]", k), bsy[k], exp_busy[k]);
      check($sformatf("rd_valid[%0d]", k), rdv[k], exp_valid[k]);
      if (rdv[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          check($sformatf("unexpected_read[%0d]", k), 1, 0);
        end else begin
          last_read[k] = sb[k].pop_front();
          check($sformatf("read_data[%0d]", k), dout[k], last_read[k]);
        end
      end else begin
        check($sformatf("hold_data[%0d]", k), dout[k], last_read[k]);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt [N_DUT];
    int r;

    // Reset, then every address reads zero.
    model_reset();
    do_reset();
    read_all();
    idle(1);

    // Write then back-to-back reads.
    step(1'b1, 1'b1, 4'd3,  8'h55, 1'b0);
    step(1'b1, 1'b1, 4'd15, 8'hA0, 1'b0);
    step(1'b1, 1'b0, 4'd3,  8'h00, 1'b0);
    check("b2b_first_data", dout[0], 8'h55);
    check("b2b_first_valid", rdv[0], 1);
    step(1'b1, 1'b0, 4'd15, 8'h00, 1'b0);
    check("b2b_second_data", dout[0], 8'hA0);
    check("b2b_second_valid", rdv[0], 1);

    // Hold for 5 idle cycles.
    idle(5);
    check("hold_data_after_idle", dout[0], 8'hA0);
    check("hold_valid_after_idle", rdv[0], 0);

    // Clear with a same-cycle write, writes attempted while busy.
    fill(8'hFF);
    step(1'b1, 1'b1, 4'd5, 8'h12, 1'b1);
    for (int k = 0; k < N_DUT; k++) busy_cnt[k] = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N_DUT; k++) if (bsy[k] === 1'b1) busy_cnt[k]++;
      step(i < 9, 1'b1, 4'(i), 8'h3C, 1'b0);
    end
    check("busy_cycles_d16", busy_cnt[0], 16);
    check("busy_cycles_d10", busy_cnt[1], 10);
    read_all();
    idle(1);

    // Reset in the middle of a clear.
    fill(8'hFF);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    idle(3);
    check("midclear_busy_before_reset", bsy[0], 1);
    do_reset();
    read_all();
    idle(1);

    // Out-of-range address on the DEPTH=10 instance.
    step(1'b1, 1'b1, 4'd12, 8'h77, 1'b0);
    step(1'b1, 1'b0, 4'd12, 8'h00, 1'b0);
    check("oor_data_d10", dout[1], 8'h00);
    check("oor_valid_d10", rdv[1], 1);
    check("inrange_data_d16", dout[0], 8'h77);
    for (int a = 0; a < 10; a++) step(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom),
             8'($urandom), r < 5);
      end
    end
    idle(20);

    for (int k = 0; k < N_DUT; k++) check($sformatf("sb_empty[%0d]", k), sb[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sram_word_array
